// File: rtl/display_272p_pkg.sv
// Shared timing defaults and types for the 480x272 RGB LCD timing generator.
package display_272p_pkg;

  localparam int CORDW = 10;
  typedef logic [CORDW-1:0] coord_t;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int DEF_H_RES  = 480;
  localparam int DEF_H_FP   = 2;
  localparam int DEF_H_SYNC = 41;
  localparam int DEF_H_BP   = 2;
  localparam int DEF_V_RES  = 272;
  localparam int DEF_V_FP   = 2;
  localparam int DEF_V_SYNC = 10;
  localparam int DEF_V_BP   = 2;

endpackage

// File: rtl/display_272p_axis.sv
// One timing axis: wrapping position counter plus decode of active and sync windows
// taken from the counter's next value, so the caller can register them alongside it.
module display_axis
  import display_272p_pkg::*;
#(
  parameter int W    = 10,
  parameter int RES  = 480,
  parameter int FP   = 2,
  parameter int SYNC = 41,
  parameter int BP   = 2
) (
  input  logic         clk_pix,
  input  logic         rst_pix_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         act_nxt,
  output logic         sync_nxt
);

  localparam logic [W-1:0] LAST    = W'(RES + FP + SYNC + BP - 1);
  localparam logic [W-1:0] RES_C   = W'(RES);
  localparam logic [W-1:0] SYNC_LO = W'(RES + FP);
  localparam logic [W-1:0] SYNC_HI = W'(RES + FP + SYNC);

  logic [W-1:0] cnt_nxt;

  always_comb begin
    wrap = en && (cnt == LAST);
    if (clr || wrap) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = cnt + W'(1);
    end else begin
      cnt_nxt = cnt;
    end
    act_nxt  = (cnt_nxt < RES_C);
    sync_nxt = (cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI);
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/display_272p.sv
// Registered display timing for 480x272 panels; every output describes the same pixel (sx, sy).
// The first edge out of reset always loads pixel (0,0) with line and frame strobes.
module display_272p
  import display_272p_pkg::*;
#(
  parameter int CORDW  = display_272p_pkg::CORDW,
  parameter int H_RES  = DEF_H_RES,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_RES  = DEF_V_RES,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter bit H_POL  = SYNC_ACTIVE_LOW,
  parameter bit V_POL  = SYNC_ACTIVE_LOW
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  if ((2**CORDW < H_TOTAL) || (2**CORDW < V_TOTAL)) begin : g_bad_cordw
    $error("display_272p: CORDW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("display_272p: porch and sync widths must be non-zero");
  end

  typedef enum logic {PRE_FRAME, RUN} state_t;
  state_t state;

  logic pre;
  logic h_wrap, h_act, h_sync;
  logic v_wrap, v_act, v_sync;

  assign pre = (state == PRE_FRAME);

  display_axis #(.W(CORDW), .RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .clr(pre), .en(!pre),
    .cnt(sx), .wrap(h_wrap), .act_nxt(h_act), .sync_nxt(h_sync)
  );

  // Vertical position only moves on the horizontal wrap, so vsync is line-aligned.
  display_axis #(.W(CORDW), .RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .clr(pre), .en(h_wrap),
    .cnt(sy), .wrap(v_wrap), .act_nxt(v_act), .sync_nxt(v_sync)
  );

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state <= PRE_FRAME;
      hsync <= !H_POL;
      vsync <= !V_POL;
      de    <= 1'b0;
      line  <= 1'b0;
      frame <= 1'b0;
    end else begin
      state <= RUN;
      hsync <= h_sync ? H_POL : !H_POL;
      vsync <= v_sync ? V_POL : !V_POL;
      de    <= h_act && v_act;
      line  <= pre || h_wrap;
      frame <= pre || v_wrap;
    end
  end

endmodule

// File: tb/tb_display_272p.sv
// Bench: default-timing instance plus a small active-high-sync instance, checked against a pixel-index model.
module tb_display_272p;

  logic clk_pix = 1'b0;
  logic rst_pix_n = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic [9:0] sx_a, sy_a, sx_b, sy_b;
  logic hs_a, vs_a, de_a, ln_a, fr_a;
  logic hs_b, vs_b, de_b, ln_b, fr_b;

  display_272p dut_a (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx_a), .sy(sy_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .line(ln_a), .frame(fr_a)
  );

  display_272p #(
    .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(8), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_b (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx_b), .sy(sy_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .line(ln_b), .frame(fr_b)
  );

  localparam int HT_B = 23;
  localparam int VT_B = 13;

  int checks = 0;
  int failures = 0;
  int cyc = -1;
  bit model_on = 1'b0;

  // Pixels elapsed since reset release; -1 while in reset.
  always @(posedge clk_pix) cyc <= rst_pix_n ? cyc + 1 : -1;

  function automatic logic [24:0] pack(int x, int y, bit hs, bit vs, bit d, bit l, bit f);
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    return {xv, yv, hs, vs, d, l, f};
  endfunction

  function automatic logic [24:0] model(int c, int hres, int hfp, int hsw, int hbp,
                                        int vres, int vfp, int vsw, int vbp, bit hp, bit vp);
    int ht, vt, x, y;
    bit hact, vact;
    if (c < 0) return pack(0, 0, !hp, !vp, 1'b0, 1'b0, 1'b0);
    ht = hres + hfp + hsw + hbp;
    vt = vres + vfp + vsw + vbp;
    x = c % ht;
    y = (c / ht) % vt;
    hact = (x >= hres + hfp) && (x < hres + hfp + hsw);
    vact = (y >= vres + vfp) && (y < vres + vfp + vsw);
    return pack(x, y, hact ? hp : !hp, vact ? vp : !vp,
                (x < hres) && (y < vres), x == 0, (x == 0) && (y == 0));
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
    if (model_on) begin
      chk("model_a", 32'({sx_a, sy_a, hs_a, vs_a, de_a, ln_a, fr_a}),
          32'(model(cyc, 480, 2, 41, 2, 272, 2, 10, 2, 1'b0, 1'b0)));
      chk("model_b", 32'({sx_b, sy_b, hs_b, vs_b, de_b, ln_b, fr_b}),
          32'(model(cyc, 16, 2, 3, 2, 8, 2, 2, 1, 1'b1, 1'b1)));
    end
  endtask

  task automatic wait_b(int tx, int ty, int budget, string nm);
    int n = 0;
    while (!(sx_b == 10'(tx) && sy_b == 10'(ty)) && n < budget) begin
      step();
      n++;
    end
    chk(nm, 32'(n < budget), 32'd1);
  endtask

  typedef struct {
    bit          rst_n;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int de_cnt, hs_cnt, ln_cnt, vs_lines, de_bad, fr_cnt, vs_glitch;
    logic vs_prev;

    for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, pack(0, 0, 1, 1, 0, 0, 0)};
    vecs[5] = '{1'b1, pack(0, 0, 1, 1, 1, 1, 1)};
    vecs[6] = '{1'b1, pack(1, 0, 1, 1, 1, 0, 0)};
    vecs[7] = '{1'b1, pack(2, 0, 1, 1, 1, 0, 0)};

    // Reset release on the default-timing instance.
    for (int i = 0; i < 8; i++) begin
      rst_pix_n = vecs[i].rst_n;
      step();
      model_on = 1'b1;
      chk($sformatf("vec%0d", i), 32'({sx_a, sy_a, hs_a, vs_a, de_a, ln_a, fr_a}), 32'(vecs[i].exp));
      if (i == 0) chk("pol_reset_b", 32'({hs_b, vs_b}), 32'd0);
    end

    // One full default line starting at sx=0.
    while (sx_a != 10'd0) step();
    de_cnt = 0;
    hs_cnt = 0;
    for (int i = 0; i < 525; i++) begin
      if (de_a) de_cnt++;
      if (!hs_a) hs_cnt++;
      step();
    end
    chk("line_de_cycles", 32'(de_cnt), 32'd480);
    chk("line_hsync_cycles", 32'(hs_cnt), 32'd41);
    chk("line_wrap", 32'({sx_a, ln_a}), 32'({10'd0, 1'b1}));

    // One full frame of the small instance.
    wait_b(0, 0, 400, "wait_frame_start");
    ln_cnt = 0; vs_lines = 0; de_bad = 0; fr_cnt = 0; vs_glitch = 0;
    vs_prev = vs_b;
    for (int i = 0; i < HT_B * VT_B; i++) begin
      if (ln_b) ln_cnt++;
      if (ln_b && vs_b) vs_lines++;
      if (de_b && sy_b >= 10'd8) de_bad++;
      if (fr_b) fr_cnt++;
      if (vs_b != vs_prev && sx_b != 10'd0) vs_glitch++;
      vs_prev = vs_b;
      step();
    end
    chk("frame_lines", 32'(ln_cnt), 32'(VT_B));
    chk("frame_vsync_lines", 32'(vs_lines), 32'd2);
    chk("frame_de_blank", 32'(de_bad), 32'd0);
    chk("frame_count", 32'(fr_cnt), 32'd1);
    chk("frame_vsync_aligned", 32'(vs_glitch), 32'd0);
    chk("frame_period", 32'({sx_b, sy_b, fr_b}), 32'({10'd0, 10'd0, 1'b1}));

    // Last pixel of the frame rolls straight into (0,0).
    wait_b(HT_B - 1, VT_B - 1, 400, "wait_corner");
    step();
    chk("corner", 32'({sx_b, sy_b, fr_b, de_b}), 32'({10'd0, 10'd0, 1'b1, 1'b1}));

    // One-cycle reset in the middle of a frame.
    wait_b(10, 5, 400, "wait_mid");
    rst_pix_n = 1'b0;
    step();
    chk("mid_reset", 32'({sx_b, sy_b, hs_b, vs_b, de_b, ln_b, fr_b}), 32'(pack(0, 0, 0, 0, 0, 0, 0)));
    rst_pix_n = 1'b1;
    step();
    chk("mid_restart", 32'({sx_b, sy_b, hs_b, vs_b, de_b, ln_b, fr_b}), 32'(pack(0, 0, 0, 0, 1, 1, 1)));

    // Random run lengths and reset pulses, checked every cycle by the model.
    for (int k = 0; k < 40; k++) begin
      int run_len, rst_len;
      run_len = $urandom_range(600, 1);
      rst_len = $urandom_range(3, 1);
      rst_pix_n = 1'b1;
      for (int i = 0; i < run_len; i++) step();
      rst_pix_n = 1'b0;
      for (int i = 0; i < rst_len; i++) step();
    end
    rst_pix_n = 1'b1;
    for (int i = 0; i < 50; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
